sa_drain: RTL and testbench

Output collector for the weight-stationary systolic array: the reader at the bottom edge of the PE grid. The bottom-row PEs emit column results skewed by one cycle per column, column 0 first. This block de-skews them into aligned row vectors and buffers them in a first-word-fall-through FIFO. It presents them downstream over a valid/ready handshake, with flow-status and sticky error flags for the feeder and control logic.

---
 rtl/sa_drain_if.sv | 28 ++
 rtl/sa_drain.sv | 115 +++++++++++
 tb/tb_sa_drain.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_drain_if.sv
// Systolic-array drain handshake bundle.
// Column results in from the PE grid, aligned row vectors out downstream.
interface sa_drain_if #(
    parameter int COLS    = 4,
    parameter int Y_WIDTH = 31
);
    logic [COLS-1:0]         i_c_vld;
    logic [COLS*Y_WIDTH-1:0] i_c;
    logic                    o_vld;
    logic                    i_rdy;
    logic [COLS*Y_WIDTH-1:0] o_y;

    modport slave (
        input  i_c_vld,
        input  i_c,
        input  i_rdy,
        output o_vld,
        output o_y
    );

    modport master (
        output i_c_vld,
        output i_c,
        output i_rdy,
        input  o_vld,
        input  o_y
    );
endinterface

// File: rtl/sa_drain.sv
// Bottom-edge collector: de-skews column results into row vectors
// and buffers them in a first-word-fall-through FIFO.
module sa_drain #(
    parameter int COLS    = 4,
    parameter int Y_WIDTH = 31,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clr,
    sa_drain_if.slave                  bus,
    output logic [$clog2(DEPTH+1)-1:0] o_cnt,
    output logic                       o_afull,
    output logic                       o_ovf,
    output logic                       o_skew_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int W  = COLS * Y_WIDTH;

    logic [COLS-1:0] av;
    logic [W-1:0]    ad;

    // Column j waits COLS-1-j cycles so all columns line up with the last one
    for (genvar j = 0; j < COLS; j++) begin : g_col
        if (j == COLS-1) begin : g_direct
            assign av[j] = bus.i_c_vld[j];
            assign ad[j*Y_WIDTH +: Y_WIDTH] = bus.i_c[j*Y_WIDTH +: Y_WIDTH];
        end else begin : g_dly
            localparam int N = COLS - 1 - j;
            logic [N-1:0]       v_q;
            logic [Y_WIDTH-1:0] d_q [N];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                end else if (i_clr) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= bus.i_c_vld[j];
                    for (int s = 1; s < N; s++) v_q[s] <= v_q[s-1];
                end
            end

            always_ff @(posedge clk) begin
                if (bus.i_c_vld[j]) d_q[0] <= bus.i_c[j*Y_WIDTH +: Y_WIDTH];
                for (int s = 1; s < N; s++)
                    if (v_q[s-1]) d_q[s] <= d_q[s-1];
            end

            assign av[j] = v_q[N-1];
            assign ad[j*Y_WIDTH +: Y_WIDTH] = d_q[N-1];
        end
    end

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, skew_q, skew_d;
    logic          all_v, part_v, full, pop, push, drop;

    assign all_v  = &av;
    assign part_v = (|av) & ~all_v;
    assign full   = (cnt_q == CW'(DEPTH));
    assign pop    = (cnt_q != '0) & bus.i_rdy & ~i_clr;
    // A pop in the same cycle frees the slot, so full only blocks a lone push
    assign push   = all_v & ~i_clr & (~full | pop);
    assign drop   = all_v & ~i_clr & full & ~pop;

    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q | drop;
        skew_d = skew_q | part_v;
        if (push) wp_d = wp_q + AW'(1);
        if (pop)  rp_d = rp_q + AW'(1);
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        if (pop && !push) cnt_d = cnt_q - CW'(1);
        if (i_clr) begin
            wp_d   = '0;
            rp_d   = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            skew_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            skew_q <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            skew_q <= skew_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= ad;
    end

    assign bus.o_vld  = (cnt_q != '0);
    assign bus.o_y    = bus.o_vld ? mem_q[rp_q] : '0;
    assign o_cnt      = cnt_q;
    assign o_afull    = (cnt_q >= CW'(DEPTH - COLS));
    assign o_ovf      = ovf_q;
    assign o_skew_err = skew_q;
endmodule

// File: tb/tb_sa_drain.sv
// Directed bench for sa_drain: skewed column driver, expected-vector queue,
// immediate assertions at every comparison point.
module tb_sa_drain;
    localparam int COLS = 4;
    localparam int YW   = 31;
    localparam int DEP  = 8;
    localparam int W    = COLS * YW;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_clr;
    logic [3:0] o_cnt;
    logic       o_afull, o_ovf, o_skew_err;

    sa_drain_if #(.COLS(COLS), .Y_WIDTH(YW)) bus ();

    sa_drain #(.COLS(COLS), .Y_WIDTH(YW), .DEPTH(DEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (i_clr),
        .bus        (bus),
        .o_cnt      (o_cnt),
        .o_afull    (o_afull),
        .o_ovf      (o_ovf),
        .o_skew_err (o_skew_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int maxc;

    bit         s_on  [64];
    int         s_base[64];
    logic [3:0] s_msk [64];
    logic [W-1:0] expq [$];

    function automatic logic [W-1:0] mkv(int b);
        logic [W-1:0] v;
        for (int j = 0; j < COLS; j++) v[j*YW +: YW] = YW'(b + j);
        return v;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_slots();
        for (int i = 0; i < 64; i++) begin
            s_on[i]   = 1'b0;
            s_base[i] = 0;
            s_msk[i]  = 4'hf;
        end
        bus.i_c_vld = '0;
        bus.i_c     = '0;
    endtask

    task automatic begin_scn();
        clr_slots();
        expq.delete();
        t = 0;
    endtask

    task automatic add(int s, int b, logic [3:0] m);
        s_on[s]   = 1'b1;
        s_base[s] = b;
        s_msk[s]  = m;
    endtask

    // Called at a falling edge: check any pop, drive step t, advance one cycle
    task automatic tick();
        int idx;
        if (bus.o_vld && bus.i_rdy) begin
            total++;
            assert (expq.size() != 0) else begin
                bad++;
                $error("FAIL stale_pop observed=%0h expected=none", bus.o_y);
            end
            if (expq.size() != 0) begin
                chk("pop_y", bus.o_y, expq[0]);
                void'(expq.pop_front());
            end
        end
        bus.i_c_vld = '0;
        bus.i_c     = '0;
        for (int j = 0; j < COLS; j++) begin
            idx = t - j;
            if (idx >= 0 && idx < 64) begin
                if (s_on[idx] && s_msk[idx][j]) begin
                    bus.i_c_vld[j] = 1'b1;
                    bus.i_c[j*YW +: YW] = YW'(s_base[idx] + j);
                end
            end
        end
        t++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_clr = 1'b0;
        bus.i_rdy = 1'b0;
        clr_slots();
        repeat (2) @(negedge clk);
        chk("rst_vld",  bus.o_vld, 0);
        chk("rst_y",    bus.o_y, 0);
        chk("rst_cnt",  o_cnt, 0);
        chk("rst_afull", o_afull, 0);
        chk("rst_ovf",  o_ovf, 0);
        chk("rst_skew", o_skew_err, 0);
        rst_n = 1'b1;

        // single vector: columns 100..103
        begin_scn();
        bus.i_rdy = 1'b1;
        add(0, 100, 4'hf);
        expq.push_back(mkv(100));
        repeat (3) tick();
        chk("single_early_vld", bus.o_vld, 0);
        tick();
        chk("single_vld", bus.o_vld, 1);
        chk("single_y",   bus.o_y, {31'd103, 31'd102, 31'd101, 31'd100});
        chk("single_cnt", o_cnt, 1);
        tick();
        chk("single_cnt0", o_cnt, 0);
        chk("single_vld0", bus.o_vld, 0);
        chk("single_y0",   bus.o_y, 0);

        // streaming: 16 back-to-back vectors
        begin_scn();
        for (int k = 0; k < 16; k++) begin
            add(k, 16*k, 4'hf);
            expq.push_back(mkv(16*k));
        end
        maxc = 0;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (int'(o_cnt) > maxc) maxc = int'(o_cnt);
        end
        chk("stream_maxcnt", maxc, 1);
        chk("stream_left", expq.size(), 0);
        chk("stream_cnt",  o_cnt, 0);
        chk("stream_ovf",  o_ovf, 0);
        chk("stream_skew", o_skew_err, 0);

        // fill and overflow
        begin_scn();
        bus.i_rdy = 1'b0;
        for (int k = 0; k < 9; k++) add(k, 'h1000 + 16*k, 4'hf);
        for (int k = 0; k < 8; k++) expq.push_back(mkv('h1000 + 16*k));
        repeat (6) tick();
        chk("fill_cnt3",   o_cnt, 3);
        chk("fill_afull0", o_afull, 0);
        tick();
        chk("fill_cnt4",   o_cnt, 4);
        chk("fill_afull1", o_afull, 1);
        repeat (4) tick();
        chk("fill_cnt8",  o_cnt, 8);
        chk("fill_ovf0",  o_ovf, 0);
        tick();
        chk("ovf_cnt8",   o_cnt, 8);
        chk("ovf_set",    o_ovf, 1);
        bus.i_rdy = 1'b1;
        repeat (9) tick();
        chk("drain_cnt",  o_cnt, 0);
        chk("drain_left", expq.size(), 0);
        chk("ovf_sticky", o_ovf, 1);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("clr_ovf", o_ovf, 0);

        // full with simultaneous push and pop, pointers wrap
        begin_scn();
        bus.i_rdy = 1'b0;
        for (int k = 0; k < 9; k++) begin
            add(k, 'h2000 + 16*k, 4'hf);
            expq.push_back(mkv('h2000 + 16*k));
        end
        repeat (11) tick();
        chk("fp_cnt8", o_cnt, 8);
        bus.i_rdy = 1'b1;
        tick();
        chk("fp_cnt_hold", o_cnt, 8);
        chk("fp_no_ovf",   o_ovf, 0);
        repeat (8) tick();
        chk("fp_cnt0", o_cnt, 0);
        chk("fp_left", expq.size(), 0);

        // skew error: column 2 missing for the middle vector
        begin_scn();
        add(0, 'h3000, 4'hf);
        add(1, 'h3010, 4'b1011);
        add(2, 'h3020, 4'hf);
        expq.push_back(mkv('h3000));
        expq.push_back(mkv('h3020));
        chk("skew_pre", o_skew_err, 0);
        repeat (7) tick();
        chk("skew_set",  o_skew_err, 1);
        chk("skew_left", expq.size(), 0);
        chk("skew_cnt",  o_cnt, 0);
        chk("skew_ovf",  o_ovf, 0);

        // clear with two vectors in de-skew and three buffered
        begin_scn();
        bus.i_rdy = 1'b0;
        for (int k = 0; k < 5; k++) add(k, 'h4000 + 16*k, 4'hf);
        repeat (6) tick();
        chk("clr_pre_cnt", o_cnt, 3);
        clr_slots();
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("clr_cnt",  o_cnt, 0);
        chk("clr_vld",  bus.o_vld, 0);
        chk("clr_y",    bus.o_y, 0);
        chk("clr_skew", o_skew_err, 0);
        chk("clr_ovf2", o_ovf, 0);
        bus.i_rdy = 1'b1;
        repeat (8) tick();
        chk("clr_after_cnt",  o_cnt, 0);
        chk("clr_after_skew", o_skew_err, 0);

        // asynchronous reset mid-stream
        begin_scn();
        bus.i_rdy = 1'b0;
        for (int k = 0; k < 5; k++) add(k, 'h5000 + 16*k, 4'hf);
        repeat (6) tick();
        chk("rst_pre_cnt", o_cnt, 3);
        #2;
        rst_n = 1'b0;
        clr_slots();
        #1;
        chk("arst_cnt", o_cnt, 0);
        chk("arst_vld", bus.o_vld, 0);
        chk("arst_y",   bus.o_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_rdy = 1'b1;
        repeat (8) tick();
        chk("arst_after_cnt",  o_cnt, 0);
        chk("arst_after_skew", o_skew_err, 0);
        chk("arst_after_ovf",  o_ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
